// File: rtl/multiply_execute_unit_l2_pkg.sv
// rtl/multiply_execute_unit_l2_pkg.sv - shared types and constants for the iterative multiply pipe
// Purpose: uop encoding, FSM state encoding, iteration-count helper.
package multiply_execute_unit_l2_pkg;

  typedef enum logic [1:0] {
    UOP_MUL    = 2'd0,
    UOP_MULH   = 2'd1,
    UOP_MULHSU = 2'd2,
    UOP_MULHU  = 2'd3
  } uop_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // Counter is wide enough for the slowest legal configuration (32 iterations).
  localparam int unsigned CNT_W = 6;

  localparam int unsigned DEFAULT_BITS_PER_CYCLE = 1;

  function automatic int unsigned num_iters(int unsigned bits_per_cycle);
    return 32 / bits_per_cycle;
  endfunction

  localparam int unsigned NUM_ITERS = num_iters(DEFAULT_BITS_PER_CYCLE);

endpackage

// File: rtl/multiply_execute_unit_l2_mul_iter_datapath.sv
// rtl/multiply_execute_unit_l2_mul_iter_datapath.sv - shift-add magnitude datapath for the multiply pipe
// Ports:
//   clk, rst           clock, synchronous active-high reset
//   start_i            capture operand magnitudes and result sign, clear accumulator
//   step_i             retire p_bits_per_cycle multiplier bits into the accumulator
//   finish_i           apply the result sign (two's-complement negate) to the accumulator
//   op1_i, op2_i, uop_i raw operands and operation, sampled on start_i
//   acc_o              64-bit accumulator
module multiply_execute_unit_l2_mul_iter_datapath
  import multiply_execute_unit_l2_pkg::*;
#(
  parameter int unsigned p_bits_per_cycle = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start_i,
  input  logic        step_i,
  input  logic        finish_i,
  input  logic [31:0] op1_i,
  input  logic [31:0] op2_i,
  input  logic [1:0]  uop_i,
  output logic [63:0] acc_o
);

  uop_e        uop;
  logic        op1_neg;
  logic        op2_neg;
  logic [31:0] mag1;
  logic [31:0] mag2;
  logic [63:0] digit;
  logic [63:0] partial;

  logic [63:0] mcand_q;
  logic [31:0] mplier_q;
  logic        neg_q;
  logic [63:0] acc_q;

  assign uop = uop_e'(uop_i);

  // op1 is signed for MULH and MULHSU, op2 only for MULH.
  assign op1_neg = ((uop == UOP_MULH) || (uop == UOP_MULHSU)) && op1_i[31];
  assign op2_neg = (uop == UOP_MULH) && op2_i[31];

  // Magnitude of 0x80000000 stays 0x80000000, valid as an unsigned value.
  assign mag1 = op1_neg ? (32'd0 - op1_i) : op1_i;
  assign mag2 = op2_neg ? (32'd0 - op2_i) : op2_i;

  // The multiplicand is pre-shifted each step, so the digit weight is implicit.
  assign digit   = {{(64 - p_bits_per_cycle){1'b0}}, mplier_q[p_bits_per_cycle-1:0]};
  assign partial = mcand_q * digit;

  always_ff @(posedge clk) begin
    if (rst) begin
      mcand_q  <= 64'd0;
      mplier_q <= 32'd0;
      neg_q    <= 1'b0;
      acc_q    <= 64'd0;
    end else if (start_i) begin
      mcand_q  <= {32'd0, mag1};
      mplier_q <= mag2;
      neg_q    <= op1_neg ^ op2_neg;
      acc_q    <= 64'd0;
    end else if (step_i) begin
      mcand_q  <= mcand_q << p_bits_per_cycle;
      mplier_q <= mplier_q >> p_bits_per_cycle;
      acc_q    <= acc_q + partial;
    end else if (finish_i) begin
      acc_q    <= neg_q ? (64'd0 - acc_q) : acc_q;
    end
  end

  assign acc_o = acc_q;

endmodule

// File: rtl/multiply_execute_unit_l2.sv
// rtl/multiply_execute_unit_l2.sv - unpipelined iterative RV32M multiply execute pipe
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   D_val/D_rdy + D_*        issue message (pc, seq_num, op1, op2, waddr, uop)
//   W_val/W_rdy + W_*        result message to writeback-commit (pc, seq_num, waddr, wdata, wen)
module multiply_execute_unit_l2
  import multiply_execute_unit_l2_pkg::*;
#(
  parameter int unsigned p_seq_num_bits   = 3,
  parameter int unsigned p_bits_per_cycle = 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      D_val,
  output logic                      D_rdy,
  input  logic [31:0]               D_pc,
  input  logic [p_seq_num_bits-1:0] D_seq_num,
  input  logic [31:0]               D_op1,
  input  logic [31:0]               D_op2,
  input  logic [4:0]                D_waddr,
  input  logic [1:0]                D_uop,
  output logic                      W_val,
  input  logic                      W_rdy,
  output logic [31:0]               W_pc,
  output logic [p_seq_num_bits-1:0] W_seq_num,
  output logic [4:0]                W_waddr,
  output logic [31:0]               W_wdata,
  output logic                      W_wen
);

  localparam int unsigned ITERS = num_iters(p_bits_per_cycle);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(ITERS);

  state_e                    state_q, state_d;
  logic [CNT_W-1:0]          cnt_q, cnt_d;
  logic [31:0]               pc_q;
  logic [p_seq_num_bits-1:0] seq_q;
  logic [4:0]                waddr_q;
  uop_e                      uop_q;

  logic        start;
  logic        step;
  logic        finish;
  logic [63:0] acc;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      pc_q    <= 32'd0;
      seq_q   <= '0;
      waddr_q <= 5'd0;
      uop_q   <= UOP_MUL;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (start) begin
        pc_q    <= D_pc;
        seq_q   <= D_seq_num;
        waddr_q <= D_waddr;
        uop_q   <= uop_e'(D_uop);
      end
    end
  end

  // CALC spends ITERS step cycles plus one cycle that applies the sign,
  // so W_val appears ITERS+1 edges after the issue handshake.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    start   = 1'b0;
    step    = 1'b0;
    finish  = 1'b0;
    D_rdy   = 1'b0;
    W_val   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        D_rdy = 1'b1;
        if (D_val) begin
          start   = 1'b1;
          cnt_d   = '0;
          state_d = ST_CALC;
        end
      end
      ST_CALC: begin
        if (cnt_q == LAST_CNT) begin
          finish  = 1'b1;
          state_d = ST_DONE;
        end else begin
          step  = 1'b1;
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_DONE: begin
        W_val = 1'b1;
        if (W_rdy) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  multiply_execute_unit_l2_mul_iter_datapath #(
    .p_bits_per_cycle(p_bits_per_cycle)
  ) u_datapath (
    .clk      (clk),
    .rst      (rst),
    .start_i  (start),
    .step_i   (step),
    .finish_i (finish),
    .op1_i    (D_op1),
    .op2_i    (D_op2),
    .uop_i    (D_uop),
    .acc_o    (acc)
  );

  assign W_pc      = pc_q;
  assign W_seq_num = seq_q;
  assign W_waddr   = waddr_q;
  assign W_wen     = (waddr_q != 5'd0);
  assign W_wdata   = (uop_q == UOP_MUL) ? acc[31:0] : acc[63:32];

  // Six ASCII chars: state, ':', two-digit counter, ':', seq digit or '-'.
  function automatic logic [47:0] trace();
    logic [7:0] st_c;
    logic [7:0] seq_c;
    case (state_q)
      ST_IDLE: st_c = "I";
      ST_CALC: st_c = "C";
      ST_DONE: st_c = "D";
      default: st_c = "?";
    endcase
    seq_c = (state_q == ST_IDLE) ? 8'h2d : (8'h30 + 8'(seq_q));
    return {st_c, 8'h3a, 8'h30 + 8'(cnt_q / 6'd10), 8'h30 + 8'(cnt_q % 6'd10), 8'h3a, seq_c};
  endfunction

endmodule

// File: tb/tb_multiply_execute_unit_l2.sv
// tb/tb_multiply_execute_unit_l2.sv - self-checking bench for the iterative multiply pipe
module tb_multiply_execute_unit_l2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        sel;
  logic        D_val;
  logic        W_rdy;
  logic [31:0] D_pc, D_op1, D_op2;
  logic [2:0]  D_seq_num;
  logic [4:0]  D_waddr;
  logic [1:0]  D_uop;

  logic        a_D_val, a_W_rdy, a_D_rdy, a_W_val, a_W_wen;
  logic [31:0] a_W_pc, a_W_wdata;
  logic [2:0]  a_W_seq_num;
  logic [4:0]  a_W_waddr;
  logic        b_D_val, b_W_rdy, b_D_rdy, b_W_val, b_W_wen;
  logic [31:0] b_W_pc, b_W_wdata;
  logic [2:0]  b_W_seq_num;
  logic [4:0]  b_W_waddr;

  assign a_D_val = D_val & ~sel;
  assign a_W_rdy = W_rdy & ~sel;
  assign b_D_val = D_val & sel;
  assign b_W_rdy = W_rdy & sel;

  logic        m_D_rdy, m_W_val, m_W_wen;
  logic [31:0] m_W_pc, m_W_wdata;
  logic [2:0]  m_W_seq_num;
  logic [4:0]  m_W_waddr;

  assign m_D_rdy     = sel ? b_D_rdy     : a_D_rdy;
  assign m_W_val     = sel ? b_W_val     : a_W_val;
  assign m_W_wen     = sel ? b_W_wen     : a_W_wen;
  assign m_W_pc      = sel ? b_W_pc      : a_W_pc;
  assign m_W_wdata   = sel ? b_W_wdata   : a_W_wdata;
  assign m_W_seq_num = sel ? b_W_seq_num : a_W_seq_num;
  assign m_W_waddr   = sel ? b_W_waddr   : a_W_waddr;

  multiply_execute_unit_l2 #(.p_seq_num_bits(3), .p_bits_per_cycle(1)) dut_p1 (
    .clk(clk), .rst(rst),
    .D_val(a_D_val), .D_rdy(a_D_rdy), .D_pc(D_pc), .D_seq_num(D_seq_num),
    .D_op1(D_op1), .D_op2(D_op2), .D_waddr(D_waddr), .D_uop(D_uop),
    .W_val(a_W_val), .W_rdy(a_W_rdy), .W_pc(a_W_pc), .W_seq_num(a_W_seq_num),
    .W_waddr(a_W_waddr), .W_wdata(a_W_wdata), .W_wen(a_W_wen)
  );

  multiply_execute_unit_l2 #(.p_seq_num_bits(3), .p_bits_per_cycle(4)) dut_p4 (
    .clk(clk), .rst(rst),
    .D_val(b_D_val), .D_rdy(b_D_rdy), .D_pc(D_pc), .D_seq_num(D_seq_num),
    .D_op1(D_op1), .D_op2(D_op2), .D_waddr(D_waddr), .D_uop(D_uop),
    .W_val(b_W_val), .W_rdy(b_W_rdy), .W_pc(b_W_pc), .W_seq_num(b_W_seq_num),
    .W_waddr(b_W_waddr), .W_wdata(b_W_wdata), .W_wen(b_W_wen)
  );

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    end
  endtask

  // Reference: full-width signed/unsigned product from plain 64-bit arithmetic.
  function automatic logic [31:0] ref_mul(input logic [1:0] uop, input logic [31:0] a,
                                          input logic [31:0] b);
    longint      sa, sb;
    logic [63:0] p;
    sa = (uop == 2'd1 || uop == 2'd2) ? longint'($signed(a)) : longint'({32'd0, a});
    sb = (uop == 2'd1) ? longint'($signed(b)) : longint'({32'd0, b});
    p  = 64'(sa * sb);
    return (uop == 2'd0) ? p[31:0] : p[63:32];
  endfunction

  task automatic do_op(input logic s, input logic [1:0] uop, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] pc, input logic [2:0] seq,
                       input logic [4:0] wa, input logic [31:0] exp, input string name);
    int lat;
    int exp_lat;
    exp_lat = s ? 9 : 33;
    sel = s;
    #1;
    chk({name, " d_rdy_idle"}, 64'(m_D_rdy), 64'd1);
    D_uop = uop; D_op1 = a; D_op2 = b; D_pc = pc; D_seq_num = seq; D_waddr = wa;
    D_val = 1'b1;
    @(posedge clk); #1;
    D_val = 1'b0;
    lat = 0;
    while (!m_W_val && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
    chk({name, " latency"}, 64'(lat), 64'(exp_lat));
    chk({name, " wdata"}, 64'(m_W_wdata), 64'(exp));
    chk({name, " wen"}, 64'(m_W_wen), 64'(wa != 5'd0));
    chk({name, " seq"}, 64'(m_W_seq_num), 64'(seq));
    chk({name, " pc"}, 64'(m_W_pc), 64'(pc));
    chk({name, " waddr"}, 64'(m_W_waddr), 64'(wa));
    W_rdy = 1'b1;
    @(posedge clk); #1;
    W_rdy = 1'b0;
    chk({name, " wval_after"}, 64'(m_W_val), 64'd0);
    chk({name, " drdy_after"}, 64'(m_D_rdy), 64'd1);
  endtask

  typedef struct {
    logic        s;
    logic [1:0]  uop;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  wa;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs[8];

  initial begin
    logic [1:0]  ru;
    logic [31:0] ra, rb;
    logic        bad;
    int          n;

    vecs[0] = '{1'b0, 2'd0, 32'd3,         32'd5,         5'd4,  32'h0000000F};
    vecs[1] = '{1'b0, 2'd3, 32'hFFFFFFFF,  32'hFFFFFFFF,  5'd7,  32'hFFFFFFFE};
    vecs[2] = '{1'b0, 2'd1, 32'hFFFFFFFF,  32'hFFFFFFFF,  5'd8,  32'h00000000};
    vecs[3] = '{1'b0, 2'd2, 32'hFFFFFFFF,  32'hFFFFFFFF,  5'd9,  32'hFFFFFFFF};
    vecs[4] = '{1'b0, 2'd0, 32'h80000000,  32'd2,         5'd10, 32'h00000000};
    vecs[5] = '{1'b0, 2'd1, 32'h80000000,  32'h80000000,  5'd11, 32'h40000000};
    vecs[6] = '{1'b0, 2'd0, 32'd7,         32'd6,         5'd0,  32'd42};
    vecs[7] = '{1'b1, 2'd3, 32'h12345678,  32'h9ABCDEF0,  5'd12, 32'h0B00EA4E};

    rst = 1'b1; sel = 1'b0; D_val = 1'b0; W_rdy = 1'b0;
    D_pc = '0; D_op1 = '0; D_op2 = '0; D_seq_num = '0; D_waddr = '0; D_uop = '0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    for (int s = 0; s < 2; s++) begin
      sel = s[0];
      #1;
      chk("reset d_rdy", 64'(m_D_rdy), 64'd1);
      chk("reset w_val", 64'(m_W_val), 64'd0);
      chk("reset w_fields", {m_W_pc, m_W_wdata}, 64'd0);
      chk("reset w_meta", {m_W_seq_num, m_W_waddr, m_W_wen}, 64'd0);
    end

    for (int i = 0; i < 8; i++)
      do_op(vecs[i].s, vecs[i].uop, vecs[i].a, vecs[i].b, 32'h1000 + 32'(i * 4),
            3'(i + 1), vecs[i].wa, vecs[i].exp, $sformatf("vec%0d", i));

    for (int i = 0; i < 4; i++)
      do_op(1'b0, 2'd0, 32'(i + 2), 32'd100, 32'h2000 + 32'(i), 3'(i), 5'd1,
            32'((i + 2) * 100), $sformatf("stream%0d", i));

    // Backpressure in DONE with a competing issue request that must be ignored.
    sel = 1'b0; #1;
    D_uop = 2'd0; D_op1 = 32'h1234; D_op2 = 32'h10; D_pc = 32'h300; D_seq_num = 3'd5; D_waddr = 5'd9;
    D_val = 1'b1;
    @(posedge clk); #1;
    D_val = 1'b0;
    n = 0;
    while (!m_W_val && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    chk("bp reached done", 64'(m_W_val), 64'd1);
    D_op1 = 32'd9; D_op2 = 32'd9; D_seq_num = 3'd6; D_pc = 32'h400;
    D_val = 1'b1;
    bad = 1'b0;
    for (int c = 0; c < 10; c++) begin
      @(posedge clk); #1;
      if (!m_W_val || m_D_rdy || m_W_wdata != 32'h12340 || m_W_pc != 32'h300 ||
          m_W_seq_num != 3'd5 || m_W_waddr != 5'd9 || !m_W_wen)
        bad = 1'b1;
    end
    chk("bp outputs held", 64'(bad), 64'd0);
    D_val = 1'b0;
    W_rdy = 1'b1;
    @(posedge clk); #1;
    W_rdy = 1'b0;
    chk("bp release w_val", 64'(m_W_val), 64'd0);
    chk("bp release d_rdy", 64'(m_D_rdy), 64'd1);
    @(posedge clk); #1;
    chk("bp no stray issue", 64'(m_D_rdy), 64'd1);

    // Reset on the tenth CALC cycle: nothing may emerge afterwards.
    D_uop = 2'd0; D_op1 = 32'd11; D_op2 = 32'd13; D_pc = 32'h500; D_seq_num = 3'd2; D_waddr = 5'd3;
    D_val = 1'b1;
    @(posedge clk); #1;
    D_val = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("rst mid d_rdy", 64'(m_D_rdy), 64'd1);
    chk("rst mid w_val", 64'(m_W_val), 64'd0);
    chk("rst mid wdata", 64'(m_W_wdata), 64'd0);
    W_rdy = 1'b1;
    bad = 1'b0;
    for (int c = 0; c < 40; c++) begin
      @(posedge clk); #1;
      if (m_W_val || !m_D_rdy) bad = 1'b1;
    end
    W_rdy = 1'b0;
    chk("rst mid no stale", 64'(bad), 64'd0);
    do_op(1'b0, 2'd0, 32'd7, 32'd6, 32'h600, 3'd4, 5'd5, 32'd42, "after_rst");

    for (int i = 0; i < 20; i++) begin
      ru = 2'($urandom_range(0, 3));
      ra = $urandom;
      rb = $urandom;
      if (i % 5 == 0) ra = 32'h80000000;
      do_op(i >= 14 ? 1'b0 : 1'b1, ru, ra, rb, $urandom, 3'($urandom), 5'($urandom),
            ref_mul(ru, ra, rb), $sformatf("rand%0d", i));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
